// File: rtl/int_pkg.sv
// ----------------------------------------------------------------------------
// int_pkg
// Shared types and constants for the interrupt controller.
//   state_e       : request/acknowledge/return handshake states
//   LOST_MAX      : saturation ceiling of the lost-edge counter
//   sat_add_lost  : saturating add used by the lost-edge counter
// ----------------------------------------------------------------------------
package int_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_e;

    localparam logic [7:0] LOST_MAX = 8'd255;

    // Adds up to 31 new lost edges to the counter and clamps at LOST_MAX.
    function automatic logic [7:0] sat_add_lost(input logic [7:0] cnt,
                                                input logic [4:0] inc);
        logic [8:0] sum;
        sum = {1'b0, cnt} + {4'b0000, inc};
        return (sum > {1'b0, LOST_MAX}) ? LOST_MAX : sum[7:0];
    endfunction

endpackage

// File: rtl/int_prio_enc.sv
// ----------------------------------------------------------------------------
// int_prio_enc
// Fixed-priority encoder: the lowest set bit of the candidate vector wins.
// Purely combinational.
//   cand  in  NSRC : candidate sources (pending and not masked)
//   valid out 1    : at least one candidate is set
//   idx   out IDW  : index of the lowest set candidate (0 when none)
// ----------------------------------------------------------------------------
module int_prio_enc #(
    parameter int NSRC = 4,
    parameter int IDW  = $clog2(NSRC)
) (
    input  logic [NSRC-1:0] cand,
    output logic            valid,
    output logic [IDW-1:0]  idx
);

    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment, otherwise synthesis infers a latch.
    always_comb begin
        valid = |cand;
        idx   = '0;
        // Scan from the top down so the lowest set index is the last write.
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (cand[i]) begin
                idx = IDW'(i);
            end
        end
    end

endmodule

// File: rtl/int_ctrl.sv
// ----------------------------------------------------------------------------
// int_ctrl
// Interrupt controller for the risc core. Edge-detects peripheral requests,
// latches them as pending, gates them with a software mask, selects one by
// fixed priority (lowest index first) and runs the INT / ack / done handshake.
//   clk         in  1    : rising-edge clock
//   rst         in  1    : synchronous active-high reset
//   irq_in      in  NSRC : source request lines, a rising edge requests
//   mask_we     in  1    : mask write strobe
//   mask_wdata  in  NSRC : new mask value (1 = masked)
//   int_ack     in  1    : core has taken the interrupt (honoured in REQ only)
//   int_done    in  1    : core returned from the ISR (honoured in SERVICE only)
//   INT         out 1    : interrupt request to the core
//   int_id      out IDW  : index of the requested / in-service source
//   int_active  out 1    : ISR in service
//   pending     out NSRC : pending register
//   mask        out NSRC : mask register
//   lost_cnt    out 8    : saturating count of edges on already-pending sources
// All outputs come straight from flops.
// ----------------------------------------------------------------------------
module int_ctrl
    import int_pkg::*;
#(
    parameter int              NSRC     = 4,
    parameter int              IDW      = $clog2(NSRC),
    parameter logic [NSRC-1:0] MASK_RST = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NSRC-1:0] irq_in,
    input  logic            mask_we,
    input  logic [NSRC-1:0] mask_wdata,
    input  logic            int_ack,
    input  logic            int_done,
    output logic            INT,
    output logic [IDW-1:0]  int_id,
    output logic            int_active,
    output logic [NSRC-1:0] pending,
    output logic [NSRC-1:0] mask,
    output logic [7:0]      lost_cnt
);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [NSRC-1:0] irq_prev_q, irq_prev_d;
    logic [NSRC-1:0] pending_q,  pending_d;
    logic [NSRC-1:0] mask_q,     mask_d;
    logic [7:0]      lost_q,     lost_d;
    state_e          state_q,    state_d;
    logic [IDW-1:0]  id_q,       id_d;
    logic            int_q,      int_d;
    logic            active_q,   active_d;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic [NSRC-1:0] rise;
    logic [NSRC-1:0] cand;
    logic [NSRC-1:0] clr_vec;
    logic [NSRC-1:0] lost_hits;
    logic [4:0]      lost_inc;
    logic            ack_take;
    logic            enc_valid;
    logic [IDW-1:0]  enc_idx;

    int_prio_enc #(
        .NSRC (NSRC),
        .IDW  (IDW)
    ) u_prio_enc (
        .cand  (cand),
        .valid (enc_valid),
        .idx   (enc_idx)
    );

    // Edge detect, pending register, mask register and lost counter.
    always_comb begin
        irq_prev_d = irq_in;
        rise       = irq_in & ~irq_prev_q;
        cand       = pending_q & ~mask_q;

        ack_take = (state_q == REQ) && int_ack;
        clr_vec  = '0;
        if (ack_take) begin
            clr_vec[id_q] = 1'b1;
        end

        // Set wins over the ack-clear: a new edge on the bit being cleared
        // leaves it pending and is not a lost edge, since the old request
        // has just been consumed by the core.
        pending_d = (pending_q & ~clr_vec) | rise;
        lost_hits = rise & pending_q & ~clr_vec;

        lost_inc = '0;
        for (int i = 0; i < NSRC; i++) begin
            lost_inc = lost_inc + 5'(lost_hits[i]);
        end
        lost_d = sat_add_lost(lost_q, lost_inc);

        mask_d = mask_we ? mask_wdata : mask_q;
    end

    // Handshake FSM: next state and registered outputs.
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        unique case (state_q)
            IDLE: begin
                if (enc_valid) begin
                    state_d = REQ;
                    id_d    = enc_idx;
                end
            end
            // The request is held until acknowledged; masking the source
            // afterwards does not withdraw it.
            REQ: begin
                if (int_ack) begin
                    state_d = SERVICE;
                end
            end
            SERVICE: begin
                if (int_done) begin
                    state_d = IDLE;
                end
            end
            // Unused encoding recovers to IDLE.
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so they appear as flops.
        int_d    = (state_d == REQ);
        active_d = (state_d == SERVICE);
    end

    // NOTE: sequential state is updated with non-blocking assignments so all
    // flops sample their _d values from the same pre-edge snapshot.
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_prev_q <= '0;
            pending_q  <= '0;
            mask_q     <= MASK_RST;
            lost_q     <= '0;
            state_q    <= IDLE;
            id_q       <= '0;
            int_q      <= 1'b0;
            active_q   <= 1'b0;
        end else begin
            irq_prev_q <= irq_prev_d;
            pending_q  <= pending_d;
            mask_q     <= mask_d;
            lost_q     <= lost_d;
            state_q    <= state_d;
            id_q       <= id_d;
            int_q      <= int_d;
            active_q   <= active_d;
        end
    end

    assign INT        = int_q;
    assign int_id     = id_q;
    assign int_active = active_q;
    assign pending    = pending_q;
    assign mask       = mask_q;
    assign lost_cnt   = lost_q;

endmodule

// File: tb/tb_int_ctrl.sv
// ----------------------------------------------------------------------------
// tb_int_ctrl
// Self-checking bench for int_ctrl (NSRC=4): directed scenarios followed by a
// randomized phase, all compared cycle by cycle with a behavioural model.
// ----------------------------------------------------------------------------
module tb_int_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] irq_in;
    logic       mask_we;
    logic [3:0] mask_wdata;
    logic       int_ack;
    logic       int_done;
    logic       int_out;
    logic [1:0] int_id;
    logic       int_active;
    logic [3:0] pending;
    logic [3:0] mask;
    logic [7:0] lost_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    // Behavioural model state.
    bit [3:0] m_prev;
    bit [3:0] m_pend;
    bit [3:0] m_mask;
    int       m_lost;
    bit       m_req;
    bit       m_svc;
    int       m_id;

    int_ctrl #(
        .NSRC     (4),
        .MASK_RST (4'b0000)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .irq_in     (irq_in),
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
        .int_ack    (int_ack),
        .int_done   (int_done),
        .INT        (int_out),
        .int_id     (int_id),
        .int_active (int_active),
        .pending    (pending),
        .mask       (mask),
        .lost_cnt   (lost_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Applies one clock edge worth of rules to the model, using the inputs
    // as they stand at the edge.
    task automatic model_edge();
        bit [3:0] rise;
        bit [3:0] np;
        int       clr;
        int       sel;
        if (rst) begin
            m_prev = '0;
            m_pend = '0;
            m_mask = '0;
            m_lost = 0;
            m_req  = 0;
            m_svc  = 0;
            m_id   = 0;
        end else begin
            rise = irq_in & ~m_prev;
            clr  = (m_req && int_ack) ? m_id : -1;
            np   = m_pend;
            for (int b = 0; b < 4; b++) begin
                if (rise[b]) begin
                    if (m_pend[b] && b != clr) m_lost = (m_lost < 255) ? m_lost + 1 : 255;
                    np[b] = 1'b1;
                end else if (b == clr) begin
                    np[b] = 1'b0;
                end
            end
            if (m_req) begin
                if (int_ack) begin
                    m_req = 0;
                    m_svc = 1;
                end
            end else if (m_svc) begin
                if (int_done) m_svc = 0;
            end else begin
                sel = -1;
                for (int b = 3; b >= 0; b--) begin
                    if (m_pend[b] && !m_mask[b]) sel = b;
                end
                if (sel >= 0) begin
                    m_req = 1;
                    m_id  = sel;
                end
            end
            m_pend = np;
            if (mask_we) m_mask = mask_wdata;
            m_prev = irq_in;
        end
    endtask

    task automatic compare_model();
        check("INT",        32'(int_out),    32'(m_req));
        check("int_id",     32'(int_id),     32'(m_id));
        check("int_active", 32'(int_active), 32'(m_svc));
        check("pending",    32'(pending),    32'(m_pend));
        check("mask",       32'(mask),       32'(m_mask));
        check("lost_cnt",   32'(lost_cnt),   32'(m_lost));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        compare_model();
    endtask

    task automatic pulse_ack();
        int_ack = 1'b1;
        cycle();
        int_ack = 1'b0;
    endtask

    task automatic pulse_done();
        int_done = 1'b1;
        cycle();
        int_done = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        irq_in     = '0;
        mask_we    = 1'b0;
        mask_wdata = '0;
        int_ack    = 1'b0;
        int_done   = 1'b0;

        // ---------------- Reset ----------------
        cycle();
        cycle();
        rst = 1'b0;
        check("rst_INT",     32'(int_out),    32'd0);
        check("rst_active",  32'(int_active), 32'd0);
        check("rst_id",      32'(int_id),     32'd0);
        check("rst_pending", 32'(pending),    32'd0);
        check("rst_mask",    32'(mask),       32'd0);
        check("rst_lost",    32'(lost_cnt),   32'd0);

        // ---------------- Single source ----------------
        irq_in = 4'b0100;
        cycle();
        irq_in = 4'b0000;
        check("single_pend_set", 32'(pending), 32'h4);
        check("single_INT_lo",   32'(int_out), 32'd0);
        cycle();
        check("single_INT_hi",   32'(int_out), 32'd1);
        check("single_id",       32'(int_id),  32'd2);
        cycle();
        cycle();
        pulse_ack();
        check("single_ack_INT",    32'(int_out),    32'd0);
        check("single_ack_active", 32'(int_active), 32'd1);
        check("single_ack_pend",   32'(pending),    32'h0);
        repeat (4) begin
            cycle();
            check("single_svc_active", 32'(int_active), 32'd1);
        end
        pulse_done();
        check("single_done_active", 32'(int_active), 32'd0);
        cycle();

        // ---------------- Priority ----------------
        irq_in = 4'b1010;
        cycle();
        irq_in = 4'b0000;
        cycle();
        check("prio_INT1", 32'(int_out), 32'd1);
        check("prio_id1",  32'(int_id),  32'd1);
        pulse_ack();
        cycle();
        pulse_done();
        check("prio_gap_INT", 32'(int_out), 32'd0);
        check("prio_gap_pend", 32'(pending), 32'h8);
        cycle();
        check("prio_INT3", 32'(int_out), 32'd1);
        check("prio_id3",  32'(int_id),  32'd3);
        pulse_ack();
        pulse_done();
        cycle();

        // ---------------- Mask ----------------
        mask_we    = 1'b1;
        mask_wdata = 4'b0001;
        cycle();
        mask_we = 1'b0;
        check("mask_written", 32'(mask), 32'h1);
        irq_in = 4'b0001;
        cycle();
        irq_in = 4'b0000;
        cycle();
        cycle();
        check("mask_pend", 32'(pending), 32'h1);
        check("mask_INT",  32'(int_out), 32'd0);
        mask_we    = 1'b1;
        mask_wdata = 4'b0000;
        cycle();
        mask_we = 1'b0;
        check("unmask_INT_lo", 32'(int_out), 32'd0);
        cycle();
        check("unmask_INT_hi", 32'(int_out), 32'd1);
        check("unmask_id",     32'(int_id),  32'd0);
        pulse_ack();
        pulse_done();
        cycle();

        // ---------------- Lost edges ----------------
        mask_we    = 1'b1;
        mask_wdata = 4'b0100;
        cycle();
        mask_we = 1'b0;
        irq_in  = 4'b0100;
        cycle();
        irq_in = 4'b0000;
        cycle();
        check("lost_first", 32'(lost_cnt), 32'd0);
        repeat (3) begin
            irq_in = 4'b0100;
            cycle();
            irq_in = 4'b0000;
            cycle();
        end
        check("lost_3", 32'(lost_cnt), 32'd3);
        repeat (300) begin
            irq_in = 4'b0100;
            cycle();
            irq_in = 4'b0000;
            cycle();
        end
        check("lost_sat", 32'(lost_cnt), 32'd255);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("lost_rst", 32'(lost_cnt), 32'd0);

        // ---------------- Set-wins collision ----------------
        irq_in = 4'b0010;
        cycle();
        irq_in = 4'b0000;
        cycle();
        check("coll_id", 32'(int_id), 32'd1);
        cycle();
        irq_in  = 4'b0010;
        int_ack = 1'b1;
        cycle();
        irq_in  = 4'b0000;
        int_ack = 1'b0;
        check("coll_pend",   32'(pending),    32'h2);
        check("coll_lost",   32'(lost_cnt),   32'd0);
        check("coll_active", 32'(int_active), 32'd1);
        pulse_done();
        cycle();
        check("coll_reINT", 32'(int_out), 32'd1);
        check("coll_reid",  32'(int_id),  32'd1);
        pulse_ack();
        pulse_done();

        // ---------------- Mid-operation reset ----------------
        mask_we    = 1'b1;
        mask_wdata = 4'b1000;
        cycle();
        mask_we = 1'b0;
        irq_in  = 4'b0101;
        cycle();
        irq_in = 4'b0000;
        cycle();
        pulse_ack();
        check("mid_active", 32'(int_active), 32'd1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("mid_INT",    32'(int_out),    32'd0);
        check("mid_active0",32'(int_active), 32'd0);
        check("mid_pend",   32'(pending),    32'h0);
        check("mid_mask",   32'(mask),       32'h0);

        // ---------------- Stray handshake ----------------
        cycle();
        pulse_ack();
        pulse_done();
        check("stray_INT",    32'(int_out),    32'd0);
        check("stray_active", 32'(int_active), 32'd0);
        check("stray_pend",   32'(pending),    32'h0);
        check("stray_id",     32'(int_id),     32'd0);

        // ---------------- Randomized ----------------
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 3) == 0) irq_in = 4'($urandom);
            mask_we    = ($urandom_range(0, 15) == 0);
            mask_wdata = 4'($urandom);
            int_ack    = ($urandom_range(0, 3) == 0);
            int_done   = ($urandom_range(0, 3) == 0);
            rst        = ($urandom_range(0, 499) == 0);
            cycle();
        end
        rst      = 1'b0;
        int_ack  = 1'b0;
        int_done = 1'b0;
        mask_we  = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
